instruction_prefetch: RTL

//  Parametrised fetch stage. Owns the fetch PC and issues single-outstanding requests on the imem
//  req/ack port. Buffers returned words with their PCs in a DEPTH-entry FIFO and hands them to

---
 rtl/instruction_prefetch.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/instruction_prefetch.sv
// rtl/instruction_prefetch.sv - fetch stage with single-outstanding imem port and prefetch FIFO
//
// Owns the fetch PC, issues one imem request at a time, buffers returned words
// together with their PCs and presents them to decode with valid/ready.
// A redirect flushes the buffer and reloads the fetch PC. A request that is still
// waiting for its ack at that moment is finished in DISCARD and its data dropped.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   redirect_i, redirect_pc_i     load new fetch PC (used as-is) and flush
//   imem_req_o, imem_addr_o       fetch request / address (held until ack)
//   imem_ack_i, imem_rdata_i      completion and read data (valid in ack cycle)
//   instr_valid_o, instr_ready_i  head-of-buffer handshake with decode
//   instruction_o, pc_out_o       head word and its PC (0 when empty)
module instruction_prefetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_ack_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instruction_o,
    output logic [ADDR_WIDTH-1:0] pc_out_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        S_FETCH   = 1'b0,
        S_DISCARD = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0]   stale_addr_q, stale_addr_d;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic [ADDR_WIDTH-1:0]   pc_mem_q   [DEPTH];
    logic [DATA_WIDTH-1:0]   data_mem_q [DEPTH];

    logic fifo_full;
    logic fifo_empty;
    logic done;
    logic push;
    logic pop;

    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);

    // Outputs are forced quiet during the reset cycle itself, since the
    // registered state only clears at the end of that cycle.
    // In FETCH the request is gated by free space; count can only grow through
    // an ack, so the request cannot drop while waiting.
    assign imem_req_o  = !rst_i && ((state_q == S_DISCARD) || !fifo_full);
    assign imem_addr_o = (state_q == S_DISCARD) ? stale_addr_q : fetch_pc_q;

    assign done = imem_req_o && imem_ack_i;
    assign push = (state_q == S_FETCH) && done && !redirect_i;

    assign instr_valid_o = !rst_i && !fifo_empty;
    assign instruction_o = instr_valid_o ? data_mem_q[rd_ptr_q] : '0;
    assign pc_out_o      = instr_valid_o ? pc_mem_q[rd_ptr_q]   : '0;

    assign pop = instr_valid_o && instr_ready_i && !redirect_i;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        stale_addr_d = stale_addr_q;
        case (state_q)
            S_FETCH: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_i;
                    // Request still pending: keep it alive at the old address
                    // and throw its data away when it returns.
                    if (imem_req_o && !imem_ack_i) begin
                        state_d      = S_DISCARD;
                        stale_addr_d = fetch_pc_q;
                    end
                end else if (done) begin
                    fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(PC_STEP);
                end
            end
            S_DISCARD: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_i;
                end
                // The stale request ends on its ack even if another redirect
                // lands in that cycle; nothing else is outstanding afterwards.
                if (imem_ack_i) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_FETCH;
            fetch_pc_q   <= RESET_PC;
            stale_addr_q <= RESET_PC;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            stale_addr_q <= stale_addr_d;
            if (redirect_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            data_mem_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

endmodule
